// File: rtl/lc4_divider_seq.sv
// lc4_divider_seq: 16-bit unsigned restoring divider, one quotient bit per cycle, trial subtract via cla16.
// Latency: result valid 16 cycles after accept (1 cycle for divisor==0 when LC4_DIV_ZERO_FAST_EN is defined).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so in_ready and out_valid never overlap.

// cla16: 16-bit adder built from four 4-bit lookahead groups with a lookahead carry across groups.
module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum
);
    always_comb begin : p_cla
        logic [14:0] g;
        logic [15:0] p;
        logic [15:0] c;
        logic [2:0]  gg;
        logic [2:0]  pg;
        logic [3:0]  gc;
        g = a[14:0] & b[14:0];
        p = a ^ b;
        for (int k = 0; k < 3; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            pg[k] = &p[4*k +: 4];
        end
        gc[0] = cin;
        gc[1] = gg[0] | (pg[0] & cin);
        gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
        gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
              | (pg[2] & pg[1] & pg[0] & cin);
        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
        sum = p ^ c;
    end
endmodule

module lc4_divider_seq #(
    parameter int ITER = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [15:0] remainder
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(ITER - 1);

    state_t      state_q, state_d;
    logic [15:0] dq_q, dq_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] dvsr_q, dvsr_d;
    logic [15:0] quot_q, quot_d;
    logic [15:0] remo_q, remo_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [16:0] rs;
    logic [15:0] diff;
    logic [15:0] rem_nxt;
    logic        c16;
    logic        ge;

    assign rs = {rem_q, dq_q[15]};

    cla16 u_sub (
        .a   (rs[15:0]),
        .b   (~dvsr_q),
        .cin (1'b1),
        .sum (diff)
    );

    // Carry-out of a + ~d + 1 rebuilt from the MSB: set means rs[15:0] >= divisor.
    assign c16     = (rs[15] & ~dvsr_q[15]) | ((rs[15] ^ ~dvsr_q[15]) & ~diff[15]);
    assign ge      = rs[16] | c16;
    assign rem_nxt = ge ? diff : rs[15:0];

    always_comb begin
        state_d = state_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
`ifdef LC4_DIV_ZERO_FAST_EN
                    if (divisor == 16'd0) begin
                        state_d = S_DONE;
                        quot_d  = '0;
                        remo_d  = '0;
                    end else begin
                        state_d = S_RUN;
                        dq_d    = dividend;
                        dvsr_d  = divisor;
                        rem_d   = '0;
                        cnt_d   = '0;
                    end
`else
                    state_d = S_RUN;
                    dq_d    = dividend;
                    dvsr_d  = divisor;
                    rem_d   = '0;
                    cnt_d   = '0;
`endif
                end
            end
            S_RUN: begin
                rem_d = rem_nxt;
                dq_d  = {dq_q[14:0], ge};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    // A zero divisor lets every trial subtract succeed; LC4 defines the result as 0/0.
                    if (dvsr_q == 16'd0) begin
                        quot_d = '0;
                        remo_d = '0;
                    end else begin
                        quot_d = {dq_q[14:0], ge};
                        remo_d = rem_nxt;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dq_q    <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dq_q    <= dq_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign quotient  = quot_q;
    assign remainder = remo_q;
endmodule

// File: tb/tb_lc4_divider_seq.sv
// Self-checking bench for lc4_divider_seq: directed corner cases plus random operands
// against a plain-arithmetic reference; honours LC4_DIV_ZERO_FAST_EN for divide-by-zero latency.
module tb_lc4_divider_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] quotient;
    logic [15:0] remainder;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lc4_divider_seq #(.ITER(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: LC4 division, x/0 defined as 0 remainder 0.
    function automatic logic [31:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        if (b == 16'd0) return 32'h0;
        return {a / b, a % b};
    endfunction

    function automatic int exp_lat(input logic [15:0] b);
`ifdef LC4_DIV_ZERO_FAST_EN
        if (b == 16'd0) return 1;
`endif
        return 16;
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input string tag, input bit hs);
        logic [31:0] e;
        int          lat;
        e = ref_div(a, b);
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat(b)));
        chk({tag, "_quot"}, 32'(quotient), 32'(e[31:16]));
        chk({tag, "_rem"}, 32'(remainder), 32'(e[15:0]));
        chk({tag, "_no_in_ready"}, 32'(in_ready), 32'd0);
        if (hs) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
            chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
            chk({tag, "_quot_hold"}, 32'(quotient), 32'(e[31:16]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pa [10];
        logic [15:0] pb [10];
        logic [31:0] e;
        int          cyc;
        int          last_acc;
        int          idx;
        int          got;

        // Reset state
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quot", 32'(quotient), 32'd0);
        chk("rst_rem", 32'(remainder), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'd100, 16'd7, "basic", 1'b1);

        run_op(16'hFFFF, 16'h0001, "sw_ffff_1", 1'b1);
        run_op(16'h8000, 16'hFFFF, "sw_8000_ffff", 1'b1);
        run_op(16'hFFFF, 16'hFFFF, "sw_ffff_ffff", 1'b1);
        run_op(16'h0000, 16'h0005, "sw_0_5", 1'b1);
        run_op(16'hFFFE, 16'h8001, "sw_fffe_8001", 1'b1);

        run_op(16'h1234, 16'h0000, "div0", 1'b1);

        // Backpressure: result held, input pulses ignored
        run_op(16'd50, 16'd6, "bp", 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            dividend = 16'($urandom);
            divisor  = 16'd3;
            chk("bp_ov_hold", 32'(out_valid), 32'd1);
            chk("bp_quot_hold", 32'(quotient), 32'd8);
            chk("bp_rem_hold", 32'(remainder), 32'd2);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        chk("bp_ov_6th", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_ov_drop", 32'(out_valid), 32'd0);
        chk("bp_in_ready_back", 32'(in_ready), 32'd1);
        chk("bp_quot_kept", 32'(quotient), 32'd8);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        dividend = 16'h5555;
        divisor  = 16'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        chk("mid_run_ov", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_quot", 32'(quotient), 32'd0);
        chk("arst_rem", 32'(remainder), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'd1000, 16'd33, "post_rst", 1'b1);

        // Random single operations, including narrow and zero divisors
        for (int i = 0; i < 20; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 16'($urandom_range(0, 15));
                1:       b = 16'($urandom_range(0, 255));
                default: b = 16'($urandom);
            endcase
            run_op(a, b, "rand", 1'b1);
        end

        // Back-to-back with in_valid and out_ready held high
        for (int i = 0; i < 10; i++) begin
            pa[i] = 16'($urandom);
            pb[i] = 16'($urandom_range(1, 65535));
            if (i % 3 == 0) pb[i] = 16'($urandom_range(1, 300));
        end
        @(negedge clk);
        dividend  = pa[0];
        divisor   = pb[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc = 0;
        last_acc = 0;
        idx = 0;
        got = 0;
        while (got < 10 && cyc < 400) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (in_ready && out_valid) chk("b2b_exclusive", 32'd1, 32'd0);
            if (in_ready && idx < 10) begin
                if (idx > 0) chk("b2b_interval", 32'(cyc - last_acc), 32'd18);
                last_acc = cyc;
                idx++;
                @(posedge clk);
                #1;
                if (idx < 10) begin
                    dividend = pa[idx];
                    divisor  = pb[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end else if (out_valid) begin
                e = ref_div(pa[got], pb[got]);
                chk("b2b_quot", 32'(quotient), 32'(e[31:16]));
                chk("b2b_rem", 32'(remainder), 32'(e[15:0]));
                got++;
            end
        end
        chk("b2b_results", 32'(got), 32'd10);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
